// File: rtl/i2c_master_sequencer.sv
// I2C master bit sequencer: runs START/STOP/WRITE/READ commands as four tick-timed phases per bit.
// Define I2C_CLOCK_STRETCH_EN to hold phase 1 until SCL is seen high on a tick (slave clock stretching).
module i2c_master_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] wdata,
    input  logic       master_ack,
    output logic [7:0] rdata,
    output logic       slave_ack,
    output logic       done,
    output logic       busy,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe
);

    typedef enum logic [2:0] {IDLE, START, STOP, DATA, ACK} state_t;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    state_t     state;
    logic [1:0] phase;
    logic [2:0] bit_cnt;
    logic       is_read;
    logic [7:0] shreg;
    logic       adv;

`ifdef I2C_CLOCK_STRETCH_EN
    // A slave holding SCL low freezes the SCL-release phase until the line is seen high.
    assign adv = tick && ((phase != 2'd1) || scl_in);
`else
    logic unused_scl;
    assign unused_scl = scl_in;
    assign adv        = tick;
`endif

    // NOTE: every state register uses non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= 2'd0;
            bit_cnt   <= 3'd0;
            is_read   <= 1'b0;
            shreg     <= 8'h00;
            rdata     <= 8'h00;
            slave_ack <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (cmd_valid && cmd_ready) begin
                    busy      <= 1'b1;
                    cmd_ready <= 1'b0;
                    phase     <= 2'd0;
                    bit_cnt   <= 3'd0;
                    is_read   <= (cmd == CMD_READ);
                    shreg     <= (cmd == CMD_WRITE) ? wdata : 8'h00;
                    case (cmd)
                        CMD_START: begin
                            state  <= START;
                            sda_oe <= 1'b0;
                        end
                        CMD_STOP: begin
                            state  <= STOP;
                            sda_oe <= 1'b1;
                        end
                        default: begin
                            state  <= DATA;
                            scl_oe <= 1'b1;
                            sda_oe <= (cmd == CMD_WRITE) ? ~wdata[7] : 1'b0;
                        end
                    endcase
                end
            end else if (adv) begin
                phase <= phase + 2'd1;
                // Each case arm sets up the line levels of the phase that follows the ending one.
                case (state)
                    START: begin
                        case (phase)
                            2'd0:    scl_oe <= 1'b0;
                            2'd1:    sda_oe <= 1'b1;
                            2'd2:    scl_oe <= 1'b1;
                            default: ;
                        endcase
                    end
                    STOP: begin
                        case (phase)
                            2'd0:    scl_oe <= 1'b0;
                            2'd1:    sda_oe <= 1'b0;
                            default: ;
                        endcase
                    end
                    DATA: begin
                        case (phase)
                            2'd0: scl_oe <= 1'b0;
                            2'd2: begin
                                scl_oe <= 1'b1;
                                if (is_read) begin
                                    shreg <= {shreg[6:0], sda_in};
                                    if (bit_cnt == 3'd7)
                                        rdata <= {shreg[6:0], sda_in};
                                end
                            end
                            2'd3: begin
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    state  <= ACK;
                                    sda_oe <= is_read ? ~master_ack : 1'b0;
                                end else if (!is_read) begin
                                    shreg  <= {shreg[6:0], 1'b0};
                                    sda_oe <= ~shreg[6];
                                end
                            end
                            default: ;
                        endcase
                    end
                    ACK: begin
                        case (phase)
                            2'd0: scl_oe <= 1'b0;
                            2'd2: begin
                                scl_oe <= 1'b1;
                                if (!is_read)
                                    slave_ack <= sda_in;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
                if ((phase == 2'd3) && (state != DATA)) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    done      <= 1'b1;
                end
            end
        end
    end

endmodule
